mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates a processor's instruction-fetch port and data port onto a single
// registered memory request channel. Ties are broken round-robin. Each access
// runs IDLE -> BUSY_x -> RESP -> IDLE. A watchdog counter aborts an access
// that the memory never acknowledges.
//
// Ports
//   clk       sole clock, rising edge
//   reset     asynchronous, active-low
//   if_req    fetch request; if_addr is the fetch address
//   if_rdata  fetched word, held between accesses
//   if_ready  one-cycle fetch completion pulse
//   d_req     data request; d_we/d_addr/d_wdata describe the access
//   d_rdata   load data (0 for stores), held between accesses
//   d_ready   one-cycle data completion pulse
//   m_req/m_we/m_addr/m_wdata  registered memory request
//   m_rdata   memory read data, sampled with m_ack
//   m_ack     single-cycle memory completion
//   stall     combinational processor hold
//   err       one-cycle pulse alongside ready when an access timed out
module mem_arbiter #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ready,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   input  logic        m_ack,
   output logic        stall,
   output logic        err
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_BUSY_IF = 2'd1;
   localparam logic [1:0] S_BUSY_D  = 2'd2;
   localparam logic [1:0] S_RESP    = 2'd3;

   localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);

   logic [1:0]  state_q, state_d;
   logic        m_req_q, m_req_d;
   logic        m_we_q, m_we_d;
   logic [31:0] m_addr_q, m_addr_d;
   logic [31:0] m_wdata_q, m_wdata_d;
   logic        if_ready_q, if_ready_d;
   logic        d_ready_q, d_ready_d;
   logic        err_q, err_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic [7:0]  cnt_q, cnt_d;
   // 1 = data port won the most recent grant, 0 = fetch port
   logic        last_grant_q, last_grant_d;

   always_comb begin
      state_d      = state_q;
      m_req_d      = m_req_q;
      m_we_d       = m_we_q;
      m_addr_d     = m_addr_q;
      m_wdata_d    = m_wdata_q;
      if_ready_d   = 1'b0;
      d_ready_d    = 1'b0;
      err_d        = 1'b0;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;

      case (state_q)
         S_IDLE: begin
            // Fetch wins when alone, or on a tie if data went last
            if (if_req && (!d_req || last_grant_q)) begin
               state_d      = S_BUSY_IF;
               m_req_d      = 1'b1;
               m_we_d       = 1'b0;
               m_addr_d     = if_addr;
               m_wdata_d    = 32'd0;
               cnt_d        = 8'd1;
               last_grant_d = 1'b0;
            end else if (d_req) begin
               state_d      = S_BUSY_D;
               m_req_d      = 1'b1;
               m_we_d       = d_we;
               m_addr_d     = d_addr;
               m_wdata_d    = d_wdata;
               cnt_d        = 8'd1;
               last_grant_d = 1'b1;
            end
         end

         S_BUSY_IF, S_BUSY_D: begin
            // An ack in the final allowed cycle still counts as success
            if (m_ack) begin
               state_d = S_RESP;
               m_req_d = 1'b0;
               cnt_d   = 8'd0;
               if (state_q == S_BUSY_IF) begin
                  if_ready_d = 1'b1;
                  if_rdata_d = m_rdata;
               end else begin
                  d_ready_d = 1'b1;
                  d_rdata_d = m_we_q ? 32'd0 : m_rdata;
               end
            end else if (cnt_q == TO_LIM) begin
               state_d = S_RESP;
               m_req_d = 1'b0;
               cnt_d   = 8'd0;
               err_d   = 1'b1;
               if (state_q == S_BUSY_IF) begin
                  if_ready_d = 1'b1;
                  if_rdata_d = 32'd0;
               end else begin
                  d_ready_d = 1'b1;
                  d_rdata_d = 32'd0;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         // Bubble cycle: no grant while ready is visible
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         m_req_q      <= 1'b0;
         m_we_q       <= 1'b0;
         m_addr_q     <= 32'd0;
         m_wdata_q    <= 32'd0;
         if_ready_q   <= 1'b0;
         d_ready_q    <= 1'b0;
         err_q        <= 1'b0;
         if_rdata_q   <= 32'd0;
         d_rdata_q    <= 32'd0;
         cnt_q        <= 8'd0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         m_req_q      <= m_req_d;
         m_we_q       <= m_we_d;
         m_addr_q     <= m_addr_d;
         m_wdata_q    <= m_wdata_d;
         if_ready_q   <= if_ready_d;
         d_ready_q    <= d_ready_d;
         err_q        <= err_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign m_req    = m_req_q;
   assign m_we     = m_we_q;
   assign m_addr   = m_addr_q;
   assign m_wdata  = m_wdata_q;
   assign if_ready = if_ready_q;
   assign d_ready  = d_ready_q;
   assign err      = err_q;
   assign if_rdata = if_rdata_q;
   assign d_rdata  = d_rdata_q;
   assign stall    = (if_req & ~if_ready_q) | (d_req & ~d_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a table of single-edge vectors for the basic
// fetch/store/load/contention/stray-ack flows, followed by hand-written
// sequences for reset, timeout and reset-during-access behaviour.
module tb_mem_arbiter;

   logic        clk;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;
   logic        m_ack;
   logic        stall;
   logic        err;

   int errors = 0;
   int checks = 0;

   mem_arbiter #(.TIMEOUT_CYC(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .if_req   (if_req),
      .if_addr  (if_addr),
      .if_rdata (if_rdata),
      .if_ready (if_ready),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_rdata  (d_rdata),
      .d_ready  (d_ready),
      .m_req    (m_req),
      .m_we     (m_we),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_rdata  (m_rdata),
      .m_ack    (m_ack),
      .stall    (stall),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        d_req;
      logic        d_we;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic        m_ack;
      logic [31:0] m_rdata;
      logic        e_m_req;
      logic        e_m_we;
      logic [31:0] e_m_addr;
      logic [31:0] e_m_wdata;
      logic        e_if_ready;
      logic        e_d_ready;
      logic [31:0] e_if_rdata;
      logic [31:0] e_d_rdata;
      logic        e_stall;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(
      input logic ir, input logic [31:0] ia,
      input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
      input logic ak, input logic [31:0] rd,
      input logic em, input logic ew, input logic [31:0] ea, input logic [31:0] ed,
      input logic eir, input logic edr, input logic [31:0] eird, input logic [31:0] edrd,
      input logic est);
      vec_t v;
      v.if_req = ir;  v.if_addr = ia;
      v.d_req = dr;   v.d_we = dw;  v.d_addr = da;  v.d_wdata = dd;
      v.m_ack = ak;   v.m_rdata = rd;
      v.e_m_req = em; v.e_m_we = ew; v.e_m_addr = ea; v.e_m_wdata = ed;
      v.e_if_ready = eir; v.e_d_ready = edr;
      v.e_if_rdata = eird; v.e_d_rdata = edrd;
      v.e_stall = est;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      if_req  = 1'b0; if_addr = 32'd0;
      d_req   = 1'b0; d_we    = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
      m_ack   = 1'b0; m_rdata = 32'd0;
   endtask

   // Issue a load and count how many cycles m_req stays high; optionally ack
   // during cycle ack_cycle (0 = never ack).
   task automatic load_with_timeout(input int ack_cycle, input logic [31:0] ack_data,
                                    input logic exp_err, input logic [31:0] exp_rdata,
                                    input string tag);
      int n;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_wdata = 32'd0;
      tick();
      n = 0;
      while (m_req === 1'b1 && n < 40) begin
         n++;
         if (n == ack_cycle) begin
            m_ack = 1'b1; m_rdata = ack_data;
         end
         tick();
         m_ack = 1'b0; m_rdata = 32'd0;
      end
      chk({tag, "_mreq_cycles"}, n, 16);
      chk({tag, "_d_ready"}, d_ready, 1'b1);
      chk({tag, "_err"}, err, exp_err);
      chk({tag, "_d_rdata"}, d_rdata, exp_rdata);
      $display("%s: m_req high %0d cycles, d_ready=%b err=%b d_rdata=%h",
               tag, n, d_ready, err, d_rdata);
      d_req = 1'b0;
      tick();
      chk({tag, "_d_ready_drop"}, d_ready, 1'b0);
      chk({tag, "_err_drop"}, err, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      idle_inputs();

      //    ifr ifaddr      dr dw daddr      dwdata        ak rdata         | m_req we addr        wdata         ifr dr if_rdata      d_rdata       stall
      // fetch only, ack one cycle after m_req
      add(1, 32'h4,   0,0,32'h0,   32'h0,        0,32'h0,        1,0,32'h4,   32'h0,        0,0,32'h0,        32'h0,        1);
      add(1, 32'h4,   0,0,32'h0,   32'h0,        0,32'h0,        1,0,32'h4,   32'h0,        0,0,32'h0,        32'h0,        1);
      add(1, 32'h4,   0,0,32'h0,   32'h0,        1,32'h00500093, 0,0,32'h0,   32'h0,        1,0,32'h00500093, 32'h0,        0);
      add(0, 32'h0,   0,0,32'h0,   32'h0,        0,32'h0,        0,0,32'h0,   32'h0,        0,0,32'h00500093, 32'h0,        0);
      // store: read data ignored, d_rdata = 0
      add(0, 32'h0,   1,1,32'h100, 32'hDEADBEEF, 0,32'h0,        1,1,32'h100, 32'hDEADBEEF, 0,0,32'h00500093, 32'h0,        1);
      add(0, 32'h0,   1,1,32'h100, 32'hDEADBEEF, 1,32'h12345678, 0,0,32'h0,   32'h0,        0,1,32'h00500093, 32'h0,        0);
      add(0, 32'h0,   0,0,32'h0,   32'h0,        0,32'h0,        0,0,32'h0,   32'h0,        0,0,32'h00500093, 32'h0,        0);
      // load
      add(0, 32'h0,   1,0,32'h200, 32'h0,        0,32'h0,        1,0,32'h200, 32'h0,        0,0,32'h00500093, 32'h0,        1);
      add(0, 32'h0,   1,0,32'h200, 32'h0,        1,32'hCAFEF00D, 0,0,32'h0,   32'h0,        0,1,32'h00500093, 32'hCAFEF00D, 0);
      add(0, 32'h0,   0,0,32'h0,   32'h0,        0,32'h0,        0,0,32'h0,   32'h0,        0,0,32'h00500093, 32'hCAFEF00D, 0);
      // contention: data went last, so fetch wins, then data, then fetch again
      add(1, 32'h8,   1,1,32'h300, 32'h55,       0,32'h0,        1,0,32'h8,   32'h0,        0,0,32'h00500093, 32'hCAFEF00D, 1);
      add(1, 32'h8,   1,1,32'h300, 32'h55,       1,32'h11111111, 0,0,32'h0,   32'h0,        1,0,32'h11111111, 32'hCAFEF00D, 1);
      add(0, 32'h0,   1,1,32'h300, 32'h55,       0,32'h0,        0,0,32'h0,   32'h0,        0,0,32'h11111111, 32'hCAFEF00D, 1);
      add(0, 32'h0,   1,1,32'h300, 32'h55,       0,32'h0,        1,1,32'h300, 32'h55,       0,0,32'h11111111, 32'hCAFEF00D, 1);
      add(0, 32'h0,   1,1,32'h300, 32'h55,       1,32'h33333333, 0,0,32'h0,   32'h0,        0,1,32'h11111111, 32'h0,        0);
      add(1, 32'h8,   1,1,32'h300, 32'h55,       0,32'h0,        0,0,32'h0,   32'h0,        0,0,32'h11111111, 32'h0,        1);
      add(1, 32'h8,   1,1,32'h300, 32'h55,       0,32'h0,        1,0,32'h8,   32'h0,        0,0,32'h11111111, 32'h0,        1);
      add(1, 32'h8,   1,1,32'h300, 32'h55,       1,32'h22222222, 0,0,32'h0,   32'h0,        1,0,32'h22222222, 32'h0,        1);
      add(0, 32'h0,   1,1,32'h300, 32'h55,       0,32'h0,        0,0,32'h0,   32'h0,        0,0,32'h22222222, 32'h0,        1);
      add(0, 32'h0,   1,1,32'h300, 32'h55,       0,32'h0,        1,1,32'h300, 32'h55,       0,0,32'h22222222, 32'h0,        1);
      add(0, 32'h0,   1,1,32'h300, 32'h55,       1,32'h44444444, 0,0,32'h0,   32'h0,        0,1,32'h22222222, 32'h0,        0);
      add(0, 32'h0,   0,0,32'h0,   32'h0,        0,32'h0,        0,0,32'h0,   32'h0,        0,0,32'h22222222, 32'h0,        0);
      // stray ack in IDLE, then prove the FSM is still IDLE with a fetch
      add(0, 32'h0,   0,0,32'h0,   32'h0,        1,32'hFFFFFFFF, 0,0,32'h0,   32'h0,        0,0,32'h22222222, 32'h0,        0);
      add(1, 32'hC,   0,0,32'h0,   32'h0,        0,32'h0,        1,0,32'hC,   32'h0,        0,0,32'h22222222, 32'h0,        1);
      add(1, 32'hC,   0,0,32'h0,   32'h0,        1,32'h0BADC0DE, 0,0,32'h0,   32'h0,        1,0,32'h0BADC0DE, 32'h0,        0);
      add(0, 32'h0,   0,0,32'h0,   32'h0,        0,32'h0,        0,0,32'h0,   32'h0,        0,0,32'h0BADC0DE, 32'h0,        0);

      // Reset state
      tick();
      tick();
      chk("rst_m_req", m_req, 1'b0);
      chk("rst_m_we", m_we, 1'b0);
      chk("rst_m_addr", m_addr, 32'h0);
      chk("rst_m_wdata", m_wdata, 32'h0);
      chk("rst_if_ready", if_ready, 1'b0);
      chk("rst_d_ready", d_ready, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      $display("reset: m_req=%b if_ready=%b d_ready=%b err=%b", m_req, if_ready, d_ready, err);
      reset = 1'b1;

      // Table-driven vectors: first grant lands on the first edge after release
      for (int i = 0; i < vecs.size(); i++) begin
         if_req  = vecs[i].if_req;  if_addr = vecs[i].if_addr;
         d_req   = vecs[i].d_req;   d_we    = vecs[i].d_we;
         d_addr  = vecs[i].d_addr;  d_wdata = vecs[i].d_wdata;
         m_ack   = vecs[i].m_ack;   m_rdata = vecs[i].m_rdata;
         tick();
         chk($sformatf("v%0d_m_req", i), m_req, vecs[i].e_m_req);
         if (vecs[i].e_m_req) begin
            chk($sformatf("v%0d_m_we", i), m_we, vecs[i].e_m_we);
            chk($sformatf("v%0d_m_addr", i), m_addr, vecs[i].e_m_addr);
            chk($sformatf("v%0d_m_wdata", i), m_wdata, vecs[i].e_m_wdata);
         end
         chk($sformatf("v%0d_if_ready", i), if_ready, vecs[i].e_if_ready);
         chk($sformatf("v%0d_d_ready", i), d_ready, vecs[i].e_d_ready);
         chk($sformatf("v%0d_err", i), err, 1'b0);
         chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].e_if_rdata);
         chk($sformatf("v%0d_d_rdata", i), d_rdata, vecs[i].e_d_rdata);
         chk($sformatf("v%0d_stall", i), stall, vecs[i].e_stall);
         $display("vec %0d: m_req=%b m_we=%b m_addr=%h if_ready=%b d_ready=%b stall=%b",
                  i, m_req, m_we, m_addr, if_ready, d_ready, stall);
      end
      idle_inputs();

      // Reset in IDLE after a fetch grant: the next tie must still go to fetch
      reset = 1'b0;
      #1;
      chk("rst2_if_rdata", if_rdata, 32'h0);
      tick();
      reset = 1'b1;
      if_req = 1'b1; if_addr = 32'h20;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
      tick();
      chk("tie_after_rst_m_req", m_req, 1'b1);
      chk("tie_after_rst_m_addr", m_addr, 32'h20);
      chk("tie_after_rst_m_we", m_we, 1'b0);
      m_ack = 1'b1; m_rdata = 32'h77;
      tick();
      m_ack = 1'b0; m_rdata = 32'h0;
      chk("tie_after_rst_if_ready", if_ready, 1'b1);
      chk("tie_after_rst_if_rdata", if_rdata, 32'h77);
      $display("tie after reset: fetch done, if_rdata=%h", if_rdata);
      if_req = 1'b0;
      tick();
      tick();
      chk("tie_after_rst_data_addr", m_addr, 32'h24);
      chk("tie_after_rst_data_req", m_req, 1'b1);
      m_ack = 1'b1; m_rdata = 32'h99;
      tick();
      m_ack = 1'b0;
      chk("tie_after_rst_d_rdata", d_rdata, 32'h99);
      d_req = 1'b0;
      tick();

      // Ack exactly in the 16th cycle succeeds; no ack at all times out
      load_with_timeout(16, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, "ack_at_16");
      load_with_timeout(0, 32'h0, 1'b1, 32'h0, "timeout");

      // Reset during BUSY_D drops m_req at once; late ack is ignored
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
      tick();
      chk("midrst_busy_m_req", m_req, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_async_m_req", m_req, 1'b0);
      chk("midrst_async_m_addr", m_addr, 32'h0);
      d_req = 1'b0;
      m_ack = 1'b1; m_rdata = 32'h5555AAAA;
      tick();
      chk("midrst_in_rst_d_ready", d_ready, 1'b0);
      chk("midrst_in_rst_err", err, 1'b0);
      reset = 1'b1;
      tick();
      m_ack = 1'b0; m_rdata = 32'h0;
      chk("midrst_after_m_req", m_req, 1'b0);
      chk("midrst_after_d_ready", d_ready, 1'b0);
      chk("midrst_after_err", err, 1'b0);
      chk("midrst_after_d_rdata", d_rdata, 32'h0);
      if_req = 1'b1; if_addr = 32'h10;
      tick();
      chk("midrst_idle_grant_m_req", m_req, 1'b1);
      chk("midrst_idle_grant_m_addr", m_addr, 32'h10);
      $display("reset mid-op: post-reset grant m_req=%b m_addr=%h", m_req, m_addr);
      idle_inputs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
